// File: rtl/psk_tx_symbol_shaper.sv
// rtl/psk_tx_symbol_shaper.sv - bit stream to 16-sample-per-symbol I/Q PSK baseband
// Held-level BPSK/QPSK symbols with linear transitions of RAMP samples between levels.
module psk_tx_symbol_shaper #(
  parameter int WIDTH   = 16,
  parameter int SPS     = 16,
  parameter int RAMP    = 8,
  parameter int AMP     = 8192,
  parameter int DIFF_EN = 0
) (
  input  logic                    clk_32M768,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [1:0]              bits_in,
  input  logic                    bits_valid,
  output logic                    bits_ready,
  output logic signed [WIDTH-1:0] I_out,
  output logic signed [WIDTH-1:0] Q_out,
  output logic                    sym_strobe,
  output logic                    underrun
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int LR = $clog2(RAMP);
  localparam int PW = WIDTH + 1 + LR;
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);
  localparam logic [CW-1:0] KSAT = CW'(RAMP - 1);
  localparam logic signed [WIDTH-1:0] LVL_P = WIDTH'(AMP);
  localparam logic signed [WIDTH-1:0] LVL_N = -LVL_P;

  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] cur_i, cur_q, prev_i, prev_q;
  logic signed [WIDTH-1:0] map_i, map_q;
  logic                    b_last, b_bit;

  assign bits_ready = en & (cnt == LAST);

  // Interpolate prev -> cur; the product is wide enough that the weight RAMP cannot overflow.
  function automatic logic signed [WIDTH-1:0] shape(
    input logic signed [WIDTH-1:0] p,
    input logic signed [WIDTH-1:0] c,
    input logic [CW-1:0]           k
  );
    logic signed [PW-1:0] d, f, prod, res;
    d = PW'(c) - PW'(p);
    if (k >= KSAT) f = PW'(RAMP);
    else           f = PW'(k) + PW'(1);
    prod = d * f;
    res  = (prod >>> LR) + PW'(p);
    return res[WIDTH-1:0];
  endfunction

  always_comb begin
    b_bit = (DIFF_EN != 0) ? (bits_in[0] ^ b_last) : bits_in[0];
    map_i = '0;
    map_q = '0;
    if (mode) begin
      map_i = bits_in[1] ? LVL_N : LVL_P;
      map_q = bits_in[0] ? LVL_N : LVL_P;
    end else begin
      map_i = b_bit ? LVL_N : LVL_P;
    end
  end

  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= LAST;
      cur_i      <= '0;
      cur_q      <= '0;
      prev_i     <= '0;
      prev_q     <= '0;
      b_last     <= 1'b0;
      I_out      <= '0;
      Q_out      <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else if (!en) begin
      cnt        <= LAST;
      cur_i      <= '0;
      cur_q      <= '0;
      prev_i     <= '0;
      prev_q     <= '0;
      I_out      <= '0;
      Q_out      <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      I_out      <= shape(prev_i, cur_i, cnt);
      Q_out      <= shape(prev_q, cur_q, cnt);
      sym_strobe <= (cnt == '0);
      underrun   <= 1'b0;
      if (cnt == LAST) begin
        cnt      <= '0;
        prev_i   <= cur_i;
        prev_q   <= cur_q;
        underrun <= ~bits_valid;
        if (bits_valid) begin
          cur_i <= map_i;
          cur_q <= map_q;
          if (!mode) b_last <= b_bit;
        end else begin
          cur_i <= '0;
          cur_q <= '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psk_tx_symbol_shaper.sv
// tb/tb_psk_tx_symbol_shaper.sv - directed self-checking bench for psk_tx_symbol_shaper
module tb_psk_tx_symbol_shaper;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               mode = 1'b0;
  logic [1:0]         bits_in = 2'b00;
  logic               bits_valid = 1'b0;
  logic               bits_ready;
  logic signed [15:0] i_out, q_out;
  logic               sym_strobe, underrun;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  psk_tx_symbol_shaper #(
    .WIDTH(16), .SPS(16), .RAMP(8), .AMP(8192), .DIFF_EN(1)
  ) dut (
    .clk_32M768 (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .bits_in    (bits_in),
    .bits_valid (bits_valid),
    .bits_ready (bits_ready),
    .I_out      (i_out),
    .Q_out      (q_out),
    .sym_strobe (sym_strobe),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with cnt at SPS-1 and the next symbol's inputs applied; leaves cnt at SPS-1 again.
  task automatic sym(input string tag, input int pi, input int pq, input int ci, input int cq,
                     input bit und);
    int m;
    tick();
    check_eq({tag, " last_i"}, i_out, pi);
    check_eq({tag, " last_q"}, q_out, pq);
    check_eq({tag, " underrun"}, int'(underrun), int'(und));
    check_eq({tag, " ready_lo"}, int'(bits_ready), 0);
    check_eq({tag, " strobe_e"}, int'(sym_strobe), 0);
    for (int k = 0; k < 15; k++) begin
      tick();
      m = (k + 1 > 8) ? 8 : k + 1;
      check_eq($sformatf("%s i k%0d", tag, k), i_out, pi + (ci - pi) * m / 8);
      check_eq($sformatf("%s q k%0d", tag, k), q_out, pq + (cq - pq) * m / 8);
      check_eq($sformatf("%s strobe k%0d", tag, k), int'(sym_strobe), (k == 0) ? 1 : 0);
    end
    check_eq({tag, " ready_hi"}, int'(bits_ready), 1);
  endtask

  initial begin
    #12;
    check_eq("rst i", i_out, 0);
    check_eq("rst q", q_out, 0);
    check_eq("rst strobe", int'(sym_strobe), 0);
    check_eq("rst underrun", int'(underrun), 0);
    check_eq("rst ready", int'(bits_ready), 0);
    tick();
    rst_n = 1'b1;
    mode = 1'b1; bits_in = 2'b00; bits_valid = 1'b1; en = 1'b1;
    #1;
    check_eq("s1 ready first", int'(bits_ready), 1);
    sym("s1", 0, 0, 8192, 8192, 1'b0);
    sym("s1 hold", 8192, 8192, 8192, 8192, 1'b0);

    bits_in = 2'b11;
    sym("s2", 8192, 8192, -8192, -8192, 1'b0);

    mode = 1'b0; bits_in = 2'b01;
    sym("s3 b1", -8192, -8192, -8192, 0, 1'b0);
    bits_in = 2'b01;
    sym("s3 b2", -8192, 0, 8192, 0, 1'b0);
    bits_in = 2'b00;
    sym("s3 b3", 8192, 0, 8192, 0, 1'b0);

    bits_valid = 1'b0;
    sym("s4 idle", 8192, 0, 0, 0, 1'b1);
    bits_valid = 1'b1; mode = 1'b1; bits_in = 2'b00;
    sym("s4 resume", 0, 0, 8192, 8192, 1'b0);

    bits_in = 2'b11;
    tick();
    for (int k = 0; k < 5; k++) tick();
    check_eq("s5 i k4", i_out, -2048);
    check_eq("s5 q k4", q_out, -2048);
    en = 1'b0;
    #1;
    check_eq("s5 ready en0", int'(bits_ready), 0);
    tick();
    check_eq("s5 i off", i_out, 0);
    check_eq("s5 q off", q_out, 0);
    check_eq("s5 strobe off", int'(sym_strobe), 0);
    tick();
    check_eq("s5 i off2", i_out, 0);
    check_eq("s5 ready off2", int'(bits_ready), 0);
    en = 1'b1;
    #1;
    check_eq("s5 ready re-en", int'(bits_ready), 1);
    bits_in = 2'b00;
    sym("s5 restart", 0, 0, 8192, 8192, 1'b0);

    bits_in = 2'b11;
    tick();
    for (int k = 0; k < 3; k++) tick();
    check_eq("s6 i k2", i_out, 2048);
    #2;
    rst_n = 1'b0; en = 1'b0;
    #1;
    check_eq("s6 rst i", i_out, 0);
    check_eq("s6 rst q", q_out, 0);
    check_eq("s6 rst strobe", int'(sym_strobe), 0);
    check_eq("s6 rst underrun", int'(underrun), 0);
    check_eq("s6 rst ready", int'(bits_ready), 0);
    tick();
    tick();
    rst_n = 1'b1; en = 1'b1; mode = 1'b1; bits_in = 2'b00;
    #1;
    check_eq("s6 ready first", int'(bits_ready), 1);
    sym("s6 post", 0, 0, 8192, 8192, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
